// File: rtl/wb_grf.sv
// -----------------------------------------------------------------------------
// wb_grf -- writeback stage and general register file of the 5-stage MIPS pipe.
//
// Selects the writeback value from the MEM/WB outputs (ALU result, data-memory
// word or link address), commits it to a 2**AW x DW register file, and serves
// two combinational read ports to decode. The selected value and the effective
// write strobe are exported for forwarding.
//
// Optional build macro: WB_GRF_BYPASS_EN
//   defined   : write-through bypass, a same-cycle read of the register being
//               written returns WDW.
//   undefined : reads return the old array contents until after the edge; any
//               W->D forwarding is done outside using WDW/WEW.
//
// Ports:
//   clk        in   clock, state updates on rising edge
//   reset      in   asynchronous active-low reset, clears the register file
//   RegWriteW  in   writeback enable
//   WriteRegW  in   destination register number [AW]
//   MemtoRegW  in   writeback select: 0 ALU, 1 DM, 2 link, 3 reserved (0)
//   ALUoutW    in   ALU result [DW]
//   DMoutW     in   data-memory read word [DW]
//   pcW        in   PC of the instruction in W [DW]
//   A1, A2     in   read addresses [AW]
//   RD1, RD2   out  read data [DW]
//   WDW        out  selected writeback value [DW]
//   WEW        out  effective write strobe (RegWriteW && WriteRegW != 0)
// -----------------------------------------------------------------------------
module wb_grf #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int LINK_OFFSET = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RegWriteW,
    input  logic [AW-1:0] WriteRegW,
    input  logic [1:0]    MemtoRegW,
    input  logic [DW-1:0] ALUoutW,
    input  logic [DW-1:0] DMoutW,
    input  logic [DW-1:0] pcW,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic [DW-1:0] WDW,
    output logic          WEW
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] r_rf [NREG];
    logic [DW-1:0] w_wd;
    logic          w_we;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;

    // Writeback select; link address wraps modulo 2**DW.
    always_comb begin
        w_wd = '0;
        case (MemtoRegW)
            2'd0:    w_wd = ALUoutW;
            2'd1:    w_wd = DMoutW;
            2'd2:    w_wd = pcW + DW'(LINK_OFFSET);
            default: w_wd = '0;
        endcase
    end

    // Register 0 is never written, so the strobe already excludes it.
    assign w_we = RegWriteW && (WriteRegW != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
        end else if (w_we) begin
            r_rf[WriteRegW] <= w_wd;
        end
    end

    // Address 0 is forced to zero explicitly so it never depends on array state.
    always_comb begin
        w_rd1 = (A1 == '0) ? '0 : r_rf[A1];
        w_rd2 = (A2 == '0) ? '0 : r_rf[A2];
`ifdef WB_GRF_BYPASS_EN
        // w_we already implies a nonzero destination, so address 0 stays 0.
        if (w_we && (A1 == WriteRegW))
            w_rd1 = w_wd;
        if (w_we && (A2 == WriteRegW))
            w_rd2 = w_wd;
`endif
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;
    assign WDW = w_wd;
    assign WEW = w_we;

endmodule

// File: tb/tb_wb_grf.sv
`timescale 1ns/100ps
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [1:0]  MemtoRegW;
    logic [31:0] ALUoutW, DMoutW, pcW;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, WDW;
    logic        WEW;

    int n_chk  = 0;
    int n_fail = 0;

    wb_grf dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .MemtoRegW(MemtoRegW), .ALUoutW(ALUoutW), .DMoutW(DMoutW), .pcW(pcW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WDW(WDW), .WEW(WEW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc);
        RegWriteW = 1'b1; WriteRegW = rd; MemtoRegW = sel;
        ALUoutW = alu; DMoutW = dm; pcW = pc;
    endtask

    initial begin
        reset = 1'b0; RegWriteW = 1'b0; WriteRegW = '0; MemtoRegW = '0;
        ALUoutW = '0; DMoutW = '0; pcW = '0; A1 = 5'd7; A2 = 5'd31;
        #2;
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_rd2", RD2, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Seed r5, then assert reset asynchronously and sweep all addresses.
        wr(5'd5, 2'd0, 32'h1234, 32'h0, 32'h0);
        #1;
        chk("r5_wew", {31'b0, WEW}, 32'h1);
        tick();
        RegWriteW = 1'b0; A1 = 5'd5;
        #1;
        chk("r5_written", RD1, 32'h1234);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = i[4:0]; A2 = 5'd31 - i[4:0];
            #0.1;
            chk($sformatf("async_clr_rd1_%0d", i), RD1, 32'h0);
            chk($sformatf("async_clr_rd2_%0d", i), RD2, 32'h0);
        end
        tick();
        reset = 1'b1;
        tick();

        // ALU write to r8
        wr(5'd8, 2'd0, 32'hDEADBEEF, 32'h12345678, 32'h0);
        #1;
        chk("alu_wdw", WDW, 32'hDEADBEEF);
        chk("alu_wew", {31'b0, WEW}, 32'h1);
        tick();
        RegWriteW = 1'b0; A1 = 5'd8; A2 = 5'd8;
        #1;
        chk("alu_rd1", RD1, 32'hDEADBEEF);
        chk("alu_rd2", RD2, 32'hDEADBEEF);

        // Link write to r31
        wr(5'd31, 2'd2, 32'h1, 32'h2, 32'h00003000);
        #1;
        chk("link_wdw", WDW, 32'h00003008);
        tick();
        RegWriteW = 1'b0; A1 = 5'd31;
        #1;
        chk("link_r31", RD1, 32'h00003008);

        // DM write to r2
        wr(5'd2, 2'd1, 32'hCAFE0000, 32'h0000007F, 32'h0);
        #1;
        chk("dm_wdw", WDW, 32'h0000007F);
        tick();
        RegWriteW = 1'b0; A2 = 5'd2;
        #1;
        chk("dm_r2", RD2, 32'h0000007F);

        // Link wrap to r3
        wr(5'd3, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFC);
        #1;
        chk("wrap_wdw", WDW, 32'h00000004);
        tick();
        RegWriteW = 1'b0; A1 = 5'd3;
        #1;
        chk("wrap_r3", RD1, 32'h00000004);

        // Reserved select writes zero over a nonzero value
        wr(5'd6, 2'd0, 32'h0000AAAA, 32'h0, 32'h0);
        tick();
        RegWriteW = 1'b0; A1 = 5'd6;
        #1;
        chk("r6_seed", RD1, 32'h0000AAAA);
        wr(5'd6, 2'd3, 32'h5555AAAA, 32'h1111, 32'h2222);
        #1;
        chk("rsv_wdw", WDW, 32'h0);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("rsv_r6", RD1, 32'h0);

        // Register 0 write suppressed
        wr(5'd0, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
        A1 = 5'd0; A2 = 5'd0;
        #1;
        chk("r0_wew", {31'b0, WEW}, 32'h0);
        chk("r0_rd1_pre", RD1, 32'h0);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("r0_rd1", RD1, 32'h0);
        chk("r0_rd2", RD2, 32'h0);

        // RegWriteW low: no write
        RegWriteW = 1'b0; WriteRegW = 5'd8; MemtoRegW = 2'd0; ALUoutW = 32'h0BAD0BAD;
        A1 = 5'd8;
        #1;
        chk("nowr_wew", {31'b0, WEW}, 32'h0);
        tick();
        chk("nowr_r8", RD1, 32'hDEADBEEF);

        // Collision on r9
        wr(5'd9, 2'd0, 32'h11, 32'h0, 32'h0);
        tick();
        wr(5'd9, 2'd0, 32'h22, 32'h0, 32'h0);
        A1 = 5'd9; A2 = 5'd9;
        #1;
`ifdef WB_GRF_BYPASS_EN
        chk("coll_rd1_pre", RD1, 32'h22);
        chk("coll_rd2_pre", RD2, 32'h22);
`else
        chk("coll_rd1_pre", RD1, 32'h11);
        chk("coll_rd2_pre", RD2, 32'h11);
`endif
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("coll_rd1_post", RD1, 32'h22);
        chk("coll_rd2_post", RD2, 32'h22);

        // Writes during reset are discarded
        reset = 1'b0;
        wr(5'd4, 2'd0, 32'h55, 32'h0, 32'h0);
        tick();
        tick();
        RegWriteW = 1'b0;
        reset = 1'b1;
        A1 = 5'd4; A2 = 5'd8;
        #1;
        chk("rstwr_r4", RD1, 32'h0);
        chk("rstwr_r8", RD2, 32'h0);
        tick();
        chk("rstwr_r4_post", RD1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
